// File: rtl/core_mem_loader_pkg.sv
// Shared definitions for the core memory loader: default memory geometry
// and the loader FSM state encoding.
package core_mem_loader_pkg;

  localparam int DEFAULT_ADDR_W = 12;
  localparam int DEFAULT_DATA_W = 32;
  localparam int BYTE_EN_W      = 4;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CHECK,
    FINISH
  } state_t;

endpackage

// File: rtl/core_mem_loader_if.sv
// Bundles the load-data stream sink and the memory port-2 master into one
// interface. The loader uses the master modport; the stream source and the
// memory behind port 2 use the slave modport.
interface core_mem_loader_if
  import core_mem_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic                 snk_valid;
  logic                 snk_ready;
  logic [DATA_W-1:0]    snk_data;

  logic [ADDR_W-1:0]    m_address;
  logic                 m_chipselect;
  logic                 m_write;
  logic [BYTE_EN_W-1:0] m_byteenable;
  logic [DATA_W-1:0]    m_writedata;
  logic                 m_clken;
  logic [DATA_W-1:0]    m_readdata;

  modport master (
    input  snk_valid,
    input  snk_data,
    input  m_readdata,
    output snk_ready,
    output m_address,
    output m_chipselect,
    output m_write,
    output m_byteenable,
    output m_writedata,
    output m_clken
  );

  modport slave (
    output snk_valid,
    output snk_data,
    output m_readdata,
    input  snk_ready,
    input  m_address,
    input  m_chipselect,
    input  m_write,
    input  m_byteenable,
    input  m_writedata,
    input  m_clken
  );

endinterface

// File: rtl/core_mem_loader.sv
// Core memory loader: streams words into a target core's memory through
// memory port 2 while holding that core in reset.
// Optional feature macro: CORE_MEM_LOADER_VERIFY_EN adds a read-back check of
// every written word (WRITE -> READ -> CHECK), reporting the first bad address.
// Without the macro, words are written one per cycle and error/err_addr are 0.
module core_mem_loader
  import core_mem_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  core_mem_loader_if.master bus,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic              in_write;
  logic              beat;
  logic              last_word;

  // An abort wins over a beat offered in the same cycle, so it also closes
  // the sink and blocks the memory strobe for that cycle.
  assign in_write  = (state == WRITE) && !abort;
  assign beat      = in_write && bus.snk_valid;
  assign last_word = (remaining == CNT_W'(1));

  assign bus.snk_ready    = in_write;
  assign bus.m_clken      = 1'b1;
  assign bus.m_address    = addr;
  assign bus.m_write      = beat;
  assign bus.m_byteenable = beat ? {BYTE_EN_W{1'b1}} : {BYTE_EN_W{1'b0}};
  assign bus.m_writedata  = bus.snk_data;

`ifdef CORE_MEM_LOADER_VERIFY_EN
  logic [DATA_W-1:0] stored;

  assign bus.m_chipselect = beat || ((state == READ) && !abort);
`else
  logic unused_readdata;

  assign unused_readdata  = ^bus.m_readdata;
  assign bus.m_chipselect = beat;
  assign error            = 1'b0;
  assign err_addr         = '0;
`endif

  // Loader FSM: tracks address and words left, and drives the status flags.
  // done is raised on entry to FINISH; busy and core_hold drop as FINISH ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      core_hold <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        state     <= IDLE;
        busy      <= 1'b0;
        core_hold <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              addr      <= base_addr;
              remaining <= word_count;
              busy      <= 1'b1;
              core_hold <= 1'b1;
              if (word_count == '0) begin
                state <= FINISH;
                done  <= 1'b1;
              end else begin
                state <= WRITE;
              end
            end
          end
          WRITE: begin
            if (beat) begin
`ifdef CORE_MEM_LOADER_VERIFY_EN
              state <= READ;
`else
              addr      <= addr + ADDR_W'(1);
              remaining <= remaining - CNT_W'(1);
              if (last_word) begin
                state <= FINISH;
                done  <= 1'b1;
              end
`endif
            end
          end
`ifdef CORE_MEM_LOADER_VERIFY_EN
          READ: begin
            state <= CHECK;
          end
          CHECK: begin
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - CNT_W'(1);
            if (last_word) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= WRITE;
            end
          end
`endif
          FINISH: begin
            busy      <= 1'b0;
            core_hold <= 1'b0;
            state     <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef CORE_MEM_LOADER_VERIFY_EN
  // Read-back checker: keeps the word just written, compares it with the
  // memory data returned in CHECK, and remembers only the first bad address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stored   <= '0;
      error    <= 1'b0;
      err_addr <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        error <= 1'b0;
      end
      if (beat) begin
        stored <= bus.snk_data;
      end
      if ((state == CHECK) && !abort && (bus.m_readdata != stored)) begin
        error <= 1'b1;
        if (!error) begin
          err_addr <= addr;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_core_mem_loader.sv
// Self-checking bench for core_mem_loader. Random and directed loads are
// compared against a simple list model: word i of a load must land at
// (base + i) mod 4096 with the i-th streamed value. A memory model answers
// port-2 reads and can corrupt one address for the read-back feature.
module tb_core_mem_loader;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 13;

  logic              clk        = 1'b0;
  logic              reset_n    = 1'b0;
  logic              start      = 1'b0;
  logic              abort      = 1'b0;
  logic [ADDR_W-1:0] base_addr  = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] err_addr;

  core_mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  core_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .word_count (word_count),
    .bus        (bus),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_addr   (err_addr)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [DATA_W-1:0] mem [0:4095];
  logic              corrupt_en   = 1'b0;
  logic [ADDR_W-1:0] corrupt_addr = 12'h005;

  logic [ADDR_W-1:0] wr_addr_q [$];
  logic [DATA_W-1:0] wr_data_q [$];
  int                wr_cyc_q  [$];
  int                done_q    [$];
  int                be_bad = 0;
  int                cs_cnt = 0;
  bit                hold_log [0:8191];

  logic [DATA_W-1:0] load_data [$];
  int                last_start_cyc = 0;

  // Cycle counter used to timestamp observed events.
  always @(posedge clk) cyc <= cyc + 1;

  // Port-2 memory model with registered read data and optional corruption.
  always @(posedge clk) begin
    if (bus.m_chipselect && bus.m_write)
      mem[bus.m_address] <= bus.m_writedata;
    if (bus.m_chipselect && !bus.m_write)
      bus.m_readdata <= mem[bus.m_address] ^
                        ((corrupt_en && (bus.m_address == corrupt_addr)) ? 32'h1 : 32'h0);
  end

  // Monitor: logs writes, done pulses, chip selects and core_hold per cycle.
  always @(negedge clk) begin
    if (bus.m_chipselect) cs_cnt++;
    if (bus.m_chipselect && bus.m_write) begin
      wr_addr_q.push_back(bus.m_address);
      wr_data_q.push_back(bus.m_writedata);
      wr_cyc_q.push_back(cyc);
      if (bus.m_byteenable != 4'hF) be_bad++;
    end
    if (done) done_q.push_back(cyc);
    hold_log[cyc % 8192] = core_hold;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic clearLogs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_q.delete();
    be_bad = 0;
    cs_cnt = 0;
  endtask

  // Runs one load of load_data at base; entered and left at posedge+1.
  task automatic applyStimulus(input string name, input logic [ADDR_W-1:0] base,
                               input int gap_pct, input bit restart,
                               input bit exp_err, input logic [ADDR_W-1:0] exp_err_addr);
    int count, idx, budget, n;
    bit acc, restarted, first;
    logic [ADDR_W-1:0] exp_addr;
    count = load_data.size();
    clearLogs();
    start = 1'b1;
    base_addr = base;
    word_count = CNT_W'(count);
    last_start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = ~base;
    word_count = CNT_W'($urandom_range(1, 4000));
    idx = 0;
    budget = 40 * count + 20;
    restarted = 1'b0;
    first = 1'b1;
    while (idx < count && budget > 0) begin
      bus.snk_valid = ($urandom_range(99) >= gap_pct);
      bus.snk_data  = load_data[idx];
      if (restart && idx == 1 && !restarted) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      @(negedge clk);
      if (first) begin
        checkOutput({name, "/busy_during"}, 32'(busy), 32'd1);
        checkOutput({name, "/hold_during"}, 32'(core_hold), 32'd1);
        first = 1'b0;
      end
      acc = bus.snk_valid && bus.snk_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) idx++;
      budget--;
    end
    bus.snk_valid = 1'b0;
    checkOutput({name, "/words_accepted"}, 32'(idx), 32'(count));
    budget = 50;
    while (busy && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    checkOutput({name, "/busy_released"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    n = wr_addr_q.size();
    checkOutput({name, "/num_writes"}, 32'(n), 32'(count));
    for (int i = 0; i < n && i < count; i++) begin
      exp_addr = base + ADDR_W'(i);
      checkOutput({name, "/write_addr"}, 32'(wr_addr_q[i]), 32'(exp_addr));
      checkOutput({name, "/write_data"}, wr_data_q[i], load_data[i]);
    end
    checkOutput({name, "/done_pulses"}, 32'(done_q.size()), 32'd1);
    checkOutput({name, "/byteenable"}, 32'(be_bad), 32'd0);
    checkOutput({name, "/hold_after"}, 32'(core_hold), 32'd0);
    checkOutput({name, "/error"}, 32'(error), 32'(exp_err));
    checkOutput({name, "/err_addr"}, 32'(err_addr), 32'(exp_err_addr));
  endtask

  // Aborts an 8-word load while the third word is on offer.
  task automatic runAbort();
    int idx, budget;
    bit acc;
    load_data.delete();
    for (int i = 0; i < 8; i++) load_data.push_back($urandom);
    clearLogs();
    start = 1'b1;
    base_addr = 12'h200;
    word_count = CNT_W'(8);
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    budget = 100;
    while (idx < 2 && budget > 0) begin
      bus.snk_valid = 1'b1;
      bus.snk_data  = load_data[idx];
      @(negedge clk);
      acc = bus.snk_valid && bus.snk_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      budget--;
    end
    checkOutput("abort/prefix_words", 32'(idx), 32'd2);
    bus.snk_valid = 1'b1;
    bus.snk_data  = load_data[2];
    abort = 1'b1;
    @(negedge clk);
    checkOutput("abort/ready_blocked", 32'(bus.snk_ready), 32'd0);
    checkOutput("abort/cs_blocked", 32'(bus.m_chipselect), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort/busy", 32'(busy), 32'd0);
    checkOutput("abort/hold", 32'(core_hold), 32'd0);
    checkOutput("abort/ready_idle", 32'(bus.snk_ready), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    bus.snk_valid = 1'b0;
    checkOutput("abort/num_writes", 32'(wr_addr_q.size()), 32'd2);
    checkOutput("abort/done_pulses", 32'(done_q.size()), 32'd0);
    if (wr_addr_q.size() >= 2) begin
      checkOutput("abort/addr0", 32'(wr_addr_q[0]), 32'h200);
      checkOutput("abort/addr1", 32'(wr_addr_q[1]), 32'h201);
    end
  endtask

  // Pulses reset mid-cycle during a load with gappy valid.
  task automatic runResetMidLoad();
    int n_before;
    clearLogs();
    start = 1'b1;
    base_addr = 12'h300;
    word_count = CNT_W'(10);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.snk_valid = ($urandom_range(99) >= 40);
      bus.snk_data  = $urandom;
      @(posedge clk); #1;
    end
    checkOutput("rst/busy_before", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    bus.snk_valid = 1'b1;
    #1;
    checkOutput("rst/busy", 32'(busy), 32'd0);
    checkOutput("rst/done", 32'(done), 32'd0);
    checkOutput("rst/hold", 32'(core_hold), 32'd0);
    checkOutput("rst/error", 32'(error), 32'd0);
    checkOutput("rst/snk_ready", 32'(bus.snk_ready), 32'd0);
    checkOutput("rst/chipselect", 32'(bus.m_chipselect), 32'd0);
    checkOutput("rst/write", 32'(bus.m_write), 32'd0);
    checkOutput("rst/address", 32'(bus.m_address), 32'd0);
    checkOutput("rst/err_addr", 32'(err_addr), 32'd0);
    n_before = wr_addr_q.size();
    @(posedge clk); #3;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.snk_valid = 1'b0;
    checkOutput("rst/no_more_writes", 32'(wr_addr_q.size()), 32'(n_before));
    checkOutput("rst/busy_after", 32'(busy), 32'd0);
    checkOutput("rst/hold_after", 32'(core_hold), 32'd0);
    checkOutput("rst/no_done", 32'(done_q.size()), 32'd0);
  endtask

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no completion, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed loads, random loads, abort, reset mid-load.
  initial begin
    int hold_sum, delta, cnt;
    logic [ADDR_W-1:0] base;
    bus.snk_valid = 1'b0;
    bus.snk_data  = '0;
    #3;
    checkOutput("reset/busy", 32'(busy), 32'd0);
    checkOutput("reset/done", 32'(done), 32'd0);
    checkOutput("reset/error", 32'(error), 32'd0);
    checkOutput("reset/hold", 32'(core_hold), 32'd0);
    checkOutput("reset/snk_ready", 32'(bus.snk_ready), 32'd0);
    checkOutput("reset/chipselect", 32'(bus.m_chipselect), 32'd0);
    checkOutput("reset/address", 32'(bus.m_address), 32'd0);
    checkOutput("reset/clken", 32'(bus.m_clken), 32'd1);
    #14;
    reset_n = 1'b1;
    @(posedge clk); #1;

    load_data.delete();
    for (int i = 0; i < 4; i++) load_data.push_back(32'hA0 + 32'(i));
    applyStimulus("seq", 12'h010, 0, 1'b0, 1'b0, '0);
`ifndef CORE_MEM_LOADER_VERIFY_EN
    if (wr_cyc_q.size() == 4 && done_q.size() == 1) begin
      checkOutput("seq/first_write_cycle", 32'(wr_cyc_q[0]), 32'(last_start_cyc + 1));
      for (int i = 1; i < 4; i++)
        checkOutput("seq/back_to_back", 32'(wr_cyc_q[i]), 32'(wr_cyc_q[0] + i));
      checkOutput("seq/done_cycle", 32'(done_q[0]), 32'(wr_cyc_q[3] + 1));
      checkOutput("seq/hold_at_done", 32'(hold_log[done_q[0] % 8192]), 32'd1);
      checkOutput("seq/hold_after_done", 32'(hold_log[(done_q[0] + 1) % 8192]), 32'd0);
    end
`endif

    load_data.delete();
    for (int i = 0; i < 3; i++) load_data.push_back($urandom);
    applyStimulus("wrap", 12'hFFE, 0, 1'b0, 1'b0, '0);

    load_data.delete();
    applyStimulus("zero", 12'h123, 0, 1'b0, 1'b0, '0);
    checkOutput("zero/no_chipselect", 32'(cs_cnt), 32'd0);
    hold_sum = 0;
    for (int c = last_start_cyc; c < last_start_cyc + 5; c++) hold_sum += hold_log[c % 8192];
    checkOutput("zero/hold_cycles", 32'(hold_sum), 32'd1);
    if (done_q.size() == 1) begin
      delta = done_q[0] - last_start_cyc;
      checkOutput("zero/done_delay_ok", 32'((delta >= 1) && (delta <= 2)), 32'd1);
    end

    for (int t = 0; t < 6; t++) begin
      base = ADDR_W'($urandom_range(0, 4095));
      cnt = $urandom_range(1, 24);
      load_data.delete();
      for (int i = 0; i < cnt; i++) load_data.push_back($urandom);
      applyStimulus("rand", base, $urandom_range(0, 50), bit'(t % 2), 1'b0, '0);
    end

    runAbort();
    runResetMidLoad();

`ifdef CORE_MEM_LOADER_VERIFY_EN
    corrupt_en = 1'b1;
    load_data.delete();
    for (int i = 0; i < 8; i++) load_data.push_back($urandom);
    applyStimulus("verify", 12'h000, 20, 1'b0, 1'b1, 12'h005);
`endif

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/core_mem_loader.md
CORE_MEM_LOADER -- requirements
Module: core_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width of target core memory.
REQ-002 SHALL have parameter DATA_W, default 32, memory word width.
REQ-003 SHALL have parameter CNT_W, default 13, width of word-count input (ADDR_W+1).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse; begins load when idle.
REQ-007 abort  input  1  terminates load in progress.
REQ-008 base_addr  input  ADDR_W  first word address written.
REQ-009 word_count  input  CNT_W  number of words to load.
REQ-010 snk_valid / snk_ready / snk_data  in/out/in  1/1/DATA_W  load-data stream sink.
REQ-011 m_address / m_chipselect / m_write / m_byteenable / m_writedata  out  ADDR_W/1/1/4/DATA_W  memory port-2 master.
REQ-012 m_clken  output  1  memory port-2 clock enable.
REQ-013 m_readdata  input  DATA_W  memory port-2 read data.
REQ-014 core_hold  output  1  drives target core reset_req during load.
REQ-015 busy / done / error  output  1/1/1  status; done is a one-cycle pulse.
REQ-016 err_addr  output  ADDR_W  address of first verify mismatch.

Function
REQ-017 FSM states SHALL be IDLE, WRITE, READ, CHECK, FINISH.
REQ-018 IDLE: start=1 SHALL latch base_addr/word_count, set busy and core_hold, go to WRITE; start ignored when not IDLE.
REQ-019 word_count=0 SHALL go IDLE->FINISH directly; no memory access.
REQ-020 WRITE: snk_ready=1; on snk_valid&snk_ready, m_chipselect=m_write=1, m_byteenable=4'hF, m_writedata=snk_data, m_address=current address, same cycle (zero added latency).
REQ-021 snk_valid=0 in WRITE SHALL stall with m_chipselect=0; no timeout.
REQ-022 snk_ready SHALL be 0 in every state except WRITE.
REQ-023 Address SHALL increment by 1 per accepted word, wrapping modulo 2^ADDR_W (4095->0).
REQ-024 After last word written (verify off) SHALL enter FINISH next cycle.
REQ-025 FINISH: done=1 for one cycle, busy=0, core_hold=0 next cycle, return IDLE.
REQ-026 abort=1 in any non-IDLE state SHALL go IDLE next cycle, no done pulse, core_hold=0, busy=0; abort has priority over same-cycle beat.
REQ-027 m_clken SHALL be 1 always; m_chipselect=0 in IDLE and FINISH.
REQ-028 error SHALL stay set until next accepted start.

Reset
REQ-029 reset_n=0 SHALL asynchronously force IDLE; busy, done, error, core_hold, snk_ready, m_chipselect, m_write = 0; m_address, err_addr, counters = 0.
REQ-030 Reset mid-load SHALL abandon load; no partial status retained.

Configuration
REQ-031 CORE_MEM_LOADER_VERIFY_EN defined: each write SHALL be followed by READ (m_chipselect=1, m_write=0, same address) then CHECK comparing m_readdata (valid one cycle after READ) to stored word; mismatch sets error and, on first mismatch only, err_addr; then WRITE or FINISH.
REQ-032 CORE_MEM_LOADER_VERIFY_EN undefined: READ/CHECK unreachable and omitted, error tied 0, err_addr tied 0, throughput one word per cycle.

Structure
REQ-033 Shared package core_mem_loader_pkg SHALL hold the FSM state enum and default ADDR_W/DATA_W constants.
REQ-034 Single module; no sub-module required.

Verification
REQ-035 base=0x010, count=4, continuous valid, data 0xA0..0xA3 -> writes at 0x010..0x013 on 4 consecutive cycles, done pulse one cycle later, core_hold drops after.
REQ-036 base=0xFFE, count=3 -> writes at 0xFFE, 0xFFF, 0x000.
REQ-037 count=0 -> no m_chipselect, done pulse 2 cycles after start, core_hold high exactly 1 cycle.
REQ-038 abort asserted after 2 of 8 words -> IDLE next cycle, no done, core_hold=0, only 2 writes issued.
REQ-039 verify enabled, memory model corrupts word at 0x005 -> error=1, err_addr=0x005, load still completes with done.
REQ-040 reset_n pulsed low mid-load with snk_valid gaps -> all outputs at reset values immediately, no further writes.
